// File: rtl/mlp_sdiv_seq.sv
// mlp_sdiv_seq: iterative signed divider, one quotient bit per clock.
// Restoring division runs on operand magnitudes; signs are reapplied when the
// result is registered. Valid/ready on both sides, and a clock enable that
// freezes every register and blocks both handshakes.
module mlp_sdiv_seq #(
   parameter int W = 14
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ce,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] dividend,
   input  logic signed [W-1:0] divisor,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [W-1:0] quot,
   output logic signed [W-1:0] rem,
   output logic                div_zero
);

   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Magnitude of a two's complement value; the most negative value maps to
   // 2^(W-1), which still fits in W unsigned bits.
   function automatic logic [W-1:0] mag_of(input logic signed [W-1:0] x);
      logic [W-1:0] u;
      u = x;
      return x[W-1] ? (~u + 1'b1) : u;
   endfunction

   // Reapply a sign to a magnitude, truncating to W bits (no saturation).
   function automatic logic [W-1:0] with_sign(input logic [W-1:0] m, input logic neg);
      return neg ? (~m + 1'b1) : m;
   endfunction

   // Control and output registers (reset)
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [W-1:0]    quot_q, quot_d;
   logic [W-1:0]    rem_q, rem_d;
   logic            dz_out_q, dz_out_d;

   // Datapath registers (no reset; only meaningful after an accept)
   logic [W-1:0]    dvd_q, dvd_d;        // dividend magnitude, becomes quotient as bits shift in
   logic [W-1:0]    dvs_q, dvs_d;        // divisor magnitude
   logic [W:0]      part_q, part_d;      // partial remainder
   logic            neg_quot_q, neg_quot_d;
   logic            neg_rem_q, neg_rem_d;
   logic            dz_op_q, dz_op_d;
   logic [W-1:0]    dvd_raw_q, dvd_raw_d; // original dividend, returned as remainder on divide-by-zero

   // One restoring step
   logic [W+1:0]    r_shift;
   logic [W+1:0]    r_sub;
   logic            take;
   logic [W-1:0]    dvd_step;

   assign in_ready  = (state_q == IDLE) && ce;
   assign out_valid = out_valid_q;
   assign quot      = quot_q;
   assign rem       = rem_q;
   assign div_zero  = dz_out_q;

   // Shift in the next dividend bit and trial-subtract the divisor; a
   // non-negative difference means the quotient bit is one.
   always_comb begin
      r_shift  = {part_q, dvd_q[W-1]};
      r_sub    = r_shift - {2'b00, dvs_q};
      take     = ~r_sub[W+1];
      dvd_step = {dvd_q[W-2:0], take};
   end

   // Next-state logic: accept operands, iterate, hold result until consumed
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      quot_d      = quot_q;
      rem_d       = rem_q;
      dz_out_d    = dz_out_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      part_d      = part_q;
      neg_quot_d  = neg_quot_q;
      neg_rem_d   = neg_rem_q;
      dz_op_d     = dz_op_q;
      dvd_raw_d   = dvd_raw_q;

      if (ce) begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  dvd_d      = mag_of(dividend);
                  dvs_d      = mag_of(divisor);
                  dvd_raw_d  = dividend;
                  neg_quot_d = dividend[W-1] ^ divisor[W-1];
                  neg_rem_d  = dividend[W-1];
                  dz_op_d    = (divisor == '0);
                  part_d     = '0;
                  cnt_d      = CW'(W - 1);
                  state_d    = CALC;
               end
            end
            CALC: begin
               dvd_d  = dvd_step;
               part_d = take ? r_sub[W:0] : r_shift[W:0];
               if (cnt_q == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  dz_out_d    = dz_op_q;
                  if (dz_op_q) begin
                     quot_d = '1;
                     rem_d  = dvd_raw_q;
                  end else begin
                     quot_d = with_sign(dvd_step, neg_quot_q);
                     rem_d  = with_sign(part_d[W-1:0], neg_rem_q);
                  end
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d     = IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // Control state and registered outputs, cleared by reset at any time
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rem_q       <= '0;
         dz_out_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         quot_q      <= quot_d;
         rem_q       <= rem_d;
         dz_out_q    <= dz_out_d;
      end
   end

   // Datapath registers; always reloaded on accept, so no reset is needed
   always_ff @(posedge clk) begin
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      part_q     <= part_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_op_q    <= dz_op_d;
      dvd_raw_q  <= dvd_raw_d;
   end

endmodule

// File: tb/tb_mlp_sdiv_seq.sv
// Testbench for mlp_sdiv_seq: directed divisions with hand-computed results,
// a scoreboard queue filled at accept time and drained by a monitor.
module tb_mlp_sdiv_seq;

   localparam int W = 14;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                ce;
   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] dividend;
   logic signed [W-1:0] divisor;
   logic                out_valid;
   logic                out_ready;
   logic [W-1:0]        quot;
   logic [W-1:0]        rem;
   logic                div_zero;

   typedef struct {
      int q;
      int r;
      int dz;
      int done_cyc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic ov_prev = 1'b0;

   mlp_sdiv_seq #(.W(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quot      (quot),
      .rem       (rem),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: latency on the rising edge of out_valid, result fields on consume
   always @(negedge clk) begin
      if (out_valid && !ov_prev) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got quot 0x%0h rem 0x%0h expected none", quot, rem);
         end else begin
            chk("latency", cyc, sb[0].done_cyc);
         end
      end
      ov_prev <= out_valid;
      if (out_valid && out_ready && ce && sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("quot", int'(quot), e.q);
         chk("rem", int'(rem), e.r);
         chk("div_zero", int'(div_zero), e.dz);
      end
   end

   // Issue one division; caller is positioned just after a rising edge
   task automatic do_div(input int a, input int b, input int eq, input int er,
                         input int edz, input int extra, input bit push);
      int n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         chk("in_ready_timeout", 0, 1);
      end else begin
         dividend = a[W-1:0];
         divisor  = b[W-1:0];
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         dividend = ~dividend;
         divisor  = divisor + 14'sd3;
         if (push) begin
            e.q = eq; e.r = er; e.dz = edz; e.done_cyc = cyc + W + extra;
            sb.push_back(e);
         end
      end
   endtask

   task automatic wait_empty();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         chk("result_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic run(input int a, input int b, input int eq, input int er, input int edz);
      do_div(a, b, eq, er, edz, 0, 1'b1);
      wait_empty();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] sq, sr;
      logic         sdz;
      int           n;

      reset_n   = 1'b0;
      ce        = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_quot", int'(quot), 0);
      chk("rst_rem", int'(rem), 0);
      chk("rst_div_zero", int'(div_zero), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      reset_n = 1'b1;
      @(posedge clk); #1;
      ce = 1'b0;
      #1;
      chk("in_ready_ce_low", int'(in_ready), 0);
      ce = 1'b1;
      #1;

      run(100, 7, 'h000E, 'h0002, 0);
      run(-100, 7, 'h3FF2, 'h3FFE, 0);
      run(100, -7, 'h3FF2, 'h0002, 0);
      run(5, 0, 'h3FFF, 'h0005, 1);
      run(-5, 0, 'h3FFF, 'h3FFB, 1);
      run(-8192, -1, 'h2000, 'h0000, 0);
      run(8191, 8191, 'h0001, 'h0000, 0);
      run(0, -3, 'h0000, 'h0000, 0);

      // Backpressure: hold the result for 5 cycles
      out_ready = 1'b0;
      do_div(1000, -33, 'h3FE2, 'h000A, 0, 0, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("bp_out_valid", int'(out_valid), 1);
      sq = quot; sr = rem; sdz = div_zero;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", int'(out_valid), 1);
         chk("bp_hold_quot", int'(quot), int'(sq));
         chk("bp_hold_rem", int'(rem), int'(sr));
         chk("bp_hold_dz", int'(div_zero), int'(sdz));
         chk("bp_in_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      wait_empty();

      // Clock-enable stall of 3 cycles in the middle of CALC
      do_div(-1000, 33, 'h3FE2, 'h3FF6, 0, 3, 1'b1);
      repeat (5) begin @(posedge clk); #1; end
      ce = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      ce = 1'b1;
      wait_empty();

      // Reset in the middle of CALC discards the operation
      do_div(100, 7, 0, 0, 0, 0, 1'b0);
      repeat (7) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", int'(out_valid), 0);
      chk("mid_rst_quot", int'(quot), 0);
      chk("mid_rst_rem", int'(rem), 0);
      chk("mid_rst_div_zero", int'(div_zero), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", int'(in_ready), 1);
      repeat (W + 2) begin @(posedge clk); #1; end
      chk("post_rst_no_result", int'(out_valid), 0);
      run(100, 7, 'h000E, 'h0002, 0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mlp_sdiv_seq.md
# mlp_sdiv_seq

Iterative signed integer divider for the MLP fixed-point datapath. It complements the pipelined 14-bit signed multiplier: it scales activations and normalises accumulators by a runtime divisor. It computes one quotient bit per clock with a restoring algorithm on magnitudes. Operands enter and results leave through valid/ready handshakes, and a clock-enable freezes the whole block, matching the `ce` behaviour of the surrounding arithmetic cores.

## Interface
- W, 14, operand, quotient and remainder width (two's complement); legal range 4..32

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- ce  in  1  clock enable; low freezes all state, and no handshake completes
- in_valid  in  1  dividend/divisor pair present
- in_ready  out  1  block can accept operands; equals (state==IDLE) && ce
- dividend  in  W  signed numerator
- divisor  in  W  signed denominator
- out_valid  out  1  quot/rem/div_zero valid; held until consumed
- out_ready  in  1  downstream accepts result
- quot  out  W  signed quotient, truncated toward zero
- rem  out  W  signed remainder, same sign as dividend (or zero)
- div_zero  out  1  result came from divisor==0

## Operation
- States:
  - IDLE: waits for operands.
  - CALC: runs W iterations under a counter that steps from W-1 down to 0.
  - DONE: holds the result.
- Accept: on a clk edge with ce && in_valid && in_ready:
  - Latch |dividend| and |divisor| as W-bit unsigned values. |−2^(W−1)| = 2^(W−1) fits.
  - Latch sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), and dz = (divisor==0).
  - Clear the partial remainder (W+1 bits) and go to CALC.
- Each CALC edge (ce high) performs one restoring step:
  - r' = {r, next dividend MSB}, then t = r' − |divisor|.
  - If t ≥ 0: r = t and the quotient bit is 1; otherwise r = r' and the quotient bit is 0.
- On the last iteration (counter==0) the same edge registers the outputs and moves to DONE:
  - quot = sign_q ? −Q : Q and rem = sign_r ? −R : R, both truncated to W bits.
  - If dz: quot = all ones (−1), rem = latched dividend, div_zero = 1. This overrides the magnitude result.
- Overflow: −2^(W−1) / −1 wraps to quot = −2^(W−1) (0x2000 for W=14), rem = 0, div_zero = 0. The block has no saturation, consistent with the truncating multiplier.
- DONE → IDLE on an edge with ce && out_ready. out_valid deasserts on that edge, while quot, rem and div_zero keep their last values.
- A divide-by-zero takes the same W-cycle latency as a normal divide, so timing is data-independent.
- Reset (any time, including mid-CALC):
  - Go to IDLE and discard any operation in flight.
  - out_valid=0, quot=0, rem=0, div_zero=0, counter=0.
  - in_ready becomes 1 as soon as ce=1.

## Timing
- Accept at edge k (ce continuously high) → out_valid=1 after edge k+W (14 cycles for W=14).
- Result consumed at the first edge with out_valid && out_ready && ce → IDLE. The next accept is possible one edge later.
- Throughput with out_ready tied high: one result per W+2 cycles.
- ce low for n cycles at any point delays every later event by exactly n cycles. Outputs, counter and partial remainder hold.
- in_ready is combinational from state and ce only, with no path from in_valid. There is no combinational path from in_* to out_*.
- out_valid, quot, rem and div_zero are registers, stable while out_valid=1 && !out_ready.
- dividend and divisor are sampled only at the accept edge and may change afterwards.

## Test plan
- 100 / 7 → quot=14 (0x000E), rem=2, div_zero=0; out_valid exactly 14 cycles after accept.
- −100 / 7 → quot=0x3FF2 (−14), rem=0x3FFE (−2). 100 / −7 → quot=0x3FF2 (−14), rem=2.
- 5 / 0 → quot=0x3FFF, rem=5, div_zero=1, same 14-cycle latency. −5 / 0 → quot=0x3FFF, rem=0x3FFB, div_zero=1.
- −8192 / −1 → quot=0x2000, rem=0. 8191 / 8191 → quot=1, rem=0. 0 / −3 → quot=0, rem=0.
- Backpressure and stall:
  - Hold out_ready=0 for 5 cycles after out_valid: outputs stable, in_ready=0 throughout.
  - Drop ce for 3 cycles mid-CALC: out_valid appears at 14+3 cycles with the correct result.
- Reset mid-operation: assert reset_n=0 at CALC iteration 7 → out_valid=0, quot=rem=0, in_ready=1 after release. A fresh 100/7 then yields 14 rem 2.
